// File: rtl/conv_post_stage_if.sv
// conv_post_stage_if: sample stream, requantisation controls and status of the conv post-processing stage
interface conv_post_stage_if #(
  parameter int IN_W = 48,
  parameter int OUT_W = 16,
  parameter int SW = $clog2(IN_W)
);
  logic i_en;
  logic signed [IN_W-1:0] i_data;
  logic [1:0] i_mode;
  logic [SW-1:0] i_shift;
  logic i_sat_clr;
  logic o_en;
  logic signed [OUT_W-1:0] o_data;
  logic o_last;
  logic o_sat;
  modport master (output i_en, i_data, i_mode, i_shift, i_sat_clr, input o_en, o_data, o_last, o_sat);
  modport slave (input i_en, i_data, i_mode, i_shift, i_sat_clr, output o_en, o_data, o_last, o_sat);
endinterface

// File: rtl/conv_post_stage.sv
// conv_post_stage: activation, round/saturate requantisation and optional 2x2 max-pool after the PE
module conv_post_stage #(
  parameter int IN_W = 48,
  parameter int OUT_W = 16,
  parameter int OUT_SIZE = 3,
  parameter int POOL_EN = 0,
  parameter int LEAKY_SHIFT = 3
) (
  input logic i_clk,
  input logic i_rst_n,
  conv_post_stage_if.slave bus
);
  localparam int SW = $clog2(IN_W);
  localparam int CW = OUT_SIZE > 1 ? $clog2(OUT_SIZE) : 1;
  localparam int IW = OUT_SIZE / 2 > 1 ? $clog2(OUT_SIZE / 2) : 1;
  localparam int PL = OUT_SIZE > 1 ? 2 * (OUT_SIZE / 2) - 1 : 0;
  localparam logic [CW-1:0] CMAX = CW'(OUT_SIZE - 1);
  localparam logic [CW-1:0] PMAX = CW'(PL);
  localparam logic signed [IN_W:0] MAXV = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] MINV = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic signed [IN_W:0] ONE = 1;
  logic first, hi, lo;
  logic [1:0] mode_e, mode_q, mode_d;
  logic [SW-1:0] shift_e, shift_q, shift_d, s1_q, s1_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d, c1_q, c1_d, r1_q, r1_d, c2_q, c2_d, r2_q, r2_d;
  logic signed [IN_W-1:0] sra, a1_q, a1_d;
  logic signed [IN_W:0] ext, rnd, y;
  logic signed [OUT_W-1:0] q, q2_q, q2_d, prev_q, prev_d, pmax, lbv, po_data_q, po_data_d;
  logic signed [OUT_W-1:0] lb_q [2**IW];
  logic signed [OUT_W-1:0] lb_d [2**IW];
  logic v1_q, v1_d, v2_q, v2_d, sat_q, sat_d, po_en_q, po_en_d, po_last_q, po_last_d;
  always_comb begin
    first = bus.i_en && col_q == '0 && row_q == '0;
    mode_e = first ? bus.i_mode : mode_q;
    shift_e = first ? bus.i_shift : shift_q;
    mode_d = mode_e;
    shift_d = shift_e;
    col_d = bus.i_en ? (col_q == CMAX ? '0 : col_q + CW'(1)) : col_q;
    row_d = bus.i_en && col_q == CMAX ? (row_q == CMAX ? '0 : row_q + CW'(1)) : row_q;
    sra = bus.i_data >>> LEAKY_SHIFT;
    v1_d = bus.i_en;
    a1_d = !bus.i_data[IN_W-1] || mode_e == 2'd0 ? bus.i_data : mode_e == 2'd2 ? sra : '0;
    s1_d = shift_e;
    c1_d = col_q;
    r1_d = row_q;
    // one extra bit keeps the rounding add from wrapping
    ext = {a1_q[IN_W-1], a1_q};
    rnd = s1_q == '0 ? '0 : ONE << (s1_q - SW'(1));
    y = (ext + rnd) >>> s1_q;
    hi = y > MAXV;
    lo = y < MINV;
    q = hi ? MAXV[OUT_W-1:0] : lo ? MINV[OUT_W-1:0] : y[OUT_W-1:0];
    v2_d = v1_q;
    q2_d = v1_q ? q : q2_q;
    c2_d = c1_q;
    r2_d = r1_q;
    sat_d = !bus.i_sat_clr && (sat_q || (v1_q && (hi || lo)));
    lbv = lb_q[IW'(c2_q >> 1)];
    pmax = q2_q > prev_q ? q2_q : prev_q;
    prev_d = v2_q && !c2_q[0] ? q2_q : prev_q;
    lb_d = lb_q;
    if (v2_q && c2_q[0] && !r2_q[0]) lb_d[IW'(c2_q >> 1)] = pmax;
    // odd trailing column/row of an odd-sized map never reaches an odd position
    po_en_d = v2_q && c2_q[0] && r2_q[0];
    po_data_d = po_en_d ? (lbv > pmax ? lbv : pmax) : po_data_q;
    po_last_d = po_en_d && c2_q == PMAX && r2_q == PMAX;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      mode_q <= '0;
      shift_q <= '0;
      col_q <= '0;
      row_q <= '0;
      v1_q <= 1'b0;
      a1_q <= '0;
      s1_q <= '0;
      c1_q <= '0;
      r1_q <= '0;
      v2_q <= 1'b0;
      q2_q <= '0;
      c2_q <= '0;
      r2_q <= '0;
      sat_q <= 1'b0;
      prev_q <= '0;
      po_en_q <= 1'b0;
      po_data_q <= '0;
      po_last_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      shift_q <= shift_d;
      col_q <= col_d;
      row_q <= row_d;
      v1_q <= v1_d;
      a1_q <= a1_d;
      s1_q <= s1_d;
      c1_q <= c1_d;
      r1_q <= r1_d;
      v2_q <= v2_d;
      q2_q <= q2_d;
      c2_q <= c2_d;
      r2_q <= r2_d;
      sat_q <= sat_d;
      prev_q <= prev_d;
      po_en_q <= po_en_d;
      po_data_q <= po_data_d;
      po_last_q <= po_last_d;
    end
  always_ff @(posedge i_clk) lb_q <= lb_d;
  assign bus.o_en = POOL_EN != 0 ? po_en_q : v2_q;
  assign bus.o_data = POOL_EN != 0 ? po_data_q : q2_q;
  assign bus.o_last = POOL_EN != 0 ? po_last_q : v2_q && c2_q == CMAX && r2_q == CMAX;
  assign bus.o_sat = sat_q;
endmodule

// File: tb/tb_conv_post_stage.sv
// tb_conv_post_stage: scoreboard bench over three configurations (3x3 no pool, 4x4 pool, 5x5 pool)
module tb_conv_post_stage;
  typedef struct {int d; bit l; int t;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int cyc = 0;
  int tests = 0;
  int failed = 0;
  exp_t q[3][$];
  conv_post_stage_if #(.IN_W(48), .OUT_W(8)) ia();
  conv_post_stage_if #(.IN_W(48), .OUT_W(16)) ib();
  conv_post_stage_if #(.IN_W(48), .OUT_W(16)) ic();
  conv_post_stage #(.IN_W(48), .OUT_W(8), .OUT_SIZE(3), .POOL_EN(0), .LEAKY_SHIFT(3))
    ua (.i_clk(clk), .i_rst_n(rst_n), .bus(ia));
  conv_post_stage #(.IN_W(48), .OUT_W(16), .OUT_SIZE(4), .POOL_EN(1), .LEAKY_SHIFT(3))
    ub (.i_clk(clk), .i_rst_n(rst_n), .bus(ib));
  conv_post_stage #(.IN_W(48), .OUT_W(16), .OUT_SIZE(5), .POOL_EN(1), .LEAKY_SHIFT(3))
    uc (.i_clk(clk), .i_rst_n(rst_n), .bus(ic));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input int id, input int d, input bit l);
    exp_t e;
    tests++;
    if (q[id].size() == 0) begin
      failed++;
      $display("FAIL out%0d unexpected: got data %0d last %0b at cycle %0d, required no output", id, d, l, cyc);
    end else begin
      e = q[id].pop_front();
      if (d !== e.d || l !== e.l || cyc !== e.t) begin
        failed++;
        $display("FAIL out%0d: got data %0d last %0b cycle %0d, required data %0d last %0b cycle %0d",
                 id, d, l, cyc, e.d, e.l, e.t);
      end
    end
  endtask
  always @(negedge clk) if (ia.o_en) chk(0, ia.o_data, ia.o_last);
  always @(negedge clk) if (ib.o_en) chk(1, ib.o_data, ib.o_last);
  always @(negedge clk) if (ic.o_en) chk(2, ic.o_data, ic.o_last);
  task automatic ck(input string n, input int act, input int req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %0d, required %0d", n, act, req);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ia.i_en = 1'b0;
      ib.i_en = 1'b0;
      ic.i_en = 1'b0;
    end
  endtask
  task automatic send(input int id, input int x, input bit h, input int e, input bit l);
    @(posedge clk);
    #1;
    ia.i_en = 1'b0;
    ib.i_en = 1'b0;
    ic.i_en = 1'b0;
    case (id)
      0: begin ia.i_en = 1'b1; ia.i_data = 48'(x); end
      1: begin ib.i_en = 1'b1; ib.i_data = 48'(x); end
      default: begin ic.i_en = 1'b1; ic.i_data = 48'(x); end
    endcase
    if (h) q[id].push_back('{e, l, cyc + (id == 0 ? 2 : 3)});
  endtask
  task automatic fa(input int v[9], input int e[9], input int clr_at);
    for (int i = 0; i < 9; i++) begin
      send(0, v[i], 1'b1, e[i], i == 8);
      ia.i_sat_clr = (i == clr_at);
    end
    ia.i_sat_clr = 1'b0;
  endtask
  initial begin
    int vb3[16];
    int eb3[16];
    ia.i_en = 0; ia.i_data = '0; ia.i_mode = 2'd0; ia.i_shift = '0; ia.i_sat_clr = 0;
    ib.i_en = 0; ib.i_data = '0; ib.i_mode = 2'd1; ib.i_shift = '0; ib.i_sat_clr = 0;
    ic.i_en = 0; ic.i_data = '0; ic.i_mode = 2'd1; ic.i_shift = '0; ic.i_sat_clr = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    ck("rst_a_en", ia.o_en, 0);
    ck("rst_a_data", ia.o_data, 0);
    ck("rst_a_last", ia.o_last, 0);
    ck("rst_a_sat", ia.o_sat, 0);
    ck("rst_b_en", ib.o_en, 0);
    ck("rst_b_data", ib.o_data, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    ia.i_mode = 2'd1;
    fa('{-5, 3, 0, 7, -1, 100, -128, 127, 2}, '{0, 3, 0, 7, 0, 100, 0, 127, 2}, -1);
    idle(4);
    ck("a_sat_quiet", ia.o_sat, 0);
    ia.i_mode = 2'd2;
    fa('{-64, -1, 8, -9, 0, 5, -800, 16, -7}, '{-8, -1, 8, -2, 0, 5, -100, 16, -1}, -1);
    ia.i_mode = 2'd0;
    begin
      int v[9] = '{-64, 1, 2, 3, 4, -3, 6, 7, 8};
      for (int i = 0; i < 9; i++) begin
        if (i == 3) ia.i_mode = 2'd1;
        send(0, v[i], 1'b1, v[i], i == 8);
      end
    end
    fa('{-3, -2, -1, 1, 2, 3, 4, 5, 6}, '{0, 0, 0, 1, 2, 3, 4, 5, 6}, -1);
    ia.i_mode = 2'd0;
    fa('{200, -300, 1, 2, 3, 4, 5, 6, 7}, '{127, -128, 1, 2, 3, 4, 5, 6, 7}, -1);
    idle(4);
    ck("a_sat_set", ia.o_sat, 1);
    @(posedge clk);
    #1 ia.i_sat_clr = 1'b1;
    @(posedge clk);
    #1 ia.i_sat_clr = 1'b0;
    ck("a_sat_clr", ia.o_sat, 0);
    fa('{300, 1, 2, 3, 4, 5, 6, 7, 8}, '{127, 1, 2, 3, 4, 5, 6, 7, 8}, 1);
    idle(4);
    ck("a_sat_clr_wins", ia.o_sat, 0);
    ia.i_shift = 6'd1;
    fa('{5, -5, 4, 3, -1, -2, 254, 256, -256}, '{3, -2, 2, 2, 0, -1, 127, 127, -128}, -1);
    idle(4);
    ck("a_sat_round", ia.o_sat, 1);
    ia.i_shift = '0;
    for (int i = 0; i < 7; i++) send(0, 10 + i, i < 5, 10 + i, 1'b0);
    @(negedge clk);
    ia.i_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    ck("arst_a_en", ia.o_en, 0);
    ck("arst_a_data", ia.o_data, 0);
    ck("arst_a_last", ia.o_last, 0);
    ck("arst_a_sat", ia.o_sat, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ia.i_mode = 2'd2;
    fa('{-64, -1, 8, -9, 0, 5, -800, 16, -7}, '{-8, -1, 8, -2, 0, 5, -100, 16, -1}, -1);
    idle(4);
    for (int i = 0; i < 16; i++) send(1, i + 1, i == 5 || i == 7 || i == 13 || i == 15, i + 1, i == 15);
    for (int i = 0; i < 16; i++) begin
      send(1, i + 1, i == 5 || i == 7 || i == 13 || i == 15, i + 1, i == 15);
      idle($urandom_range(1, 3));
    end
    ib.i_mode = 2'd0;
    vb3 = '{-5, -3, -10, -20, -7, -4, -1, -2, 3, -8, 0, 0, -1, -9, -6, -7};
    eb3 = '{0, 0, 0, 0, 0, -3, 0, -1, 0, 0, 0, 0, 0, 3, 0, 0};
    for (int i = 0; i < 16; i++) send(1, vb3[i], i == 5 || i == 7 || i == 13 || i == 15, eb3[i], i == 15);
    idle(5);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 25; i++) send(2, i + 1, i == 6 || i == 8 || i == 16 || i == 18, i + 1, i == 18);
    idle(6);
    for (int id = 0; id < 3; id++) ck($sformatf("out%0d_drained", id), q[id].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
